pipeline_debug_sequencer: RTL and testbench



---
 rtl/pipeline_debug_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_debug_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_debug_sequencer.sv
// Debug sequencer for the MIPS pipeline: gates PC/pipeline advance for
// continuous run or single step, stops on decode halt, and streams the
// register file out over a valid/ready port.
// Optional build macro DBG_CYCLE_LIMIT_EN: stops a RUN after MAX_CYCLES
// enabled cycles and raises a sticky o_timeout.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for a command, pipeline frozen
// RUN       | pipeline advancing every cycle until halt (or cycle limit)
// STEP      | single enabled cycle, then back to IDLE (or HALTED on halt)
// DUMP_RD   | debug read address presented, data captured at cycle end
// DUMP_SEND | word offered on the dump port until the consumer takes it
// HALTED    | pipeline stopped by halt; only DUMP (or reset) does anything
module pipeline_debug_sequencer #(
  parameter int N_BITS     = 32,
  parameter int N_REG_BITS = 5,
  parameter int N_REGS     = 32,
  parameter int MAX_CYCLES = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  input  logic [1:0]            i_cmd,
  output logic                  o_cmd_ready,
  input  logic                  i_halt,
  output logic                  o_pipe_enable,
  output logic [N_REG_BITS-1:0] o_dbg_reg_addr,
  input  logic [N_BITS-1:0]     i_dbg_reg_data,
  output logic                  o_dump_valid,
  output logic [N_BITS-1:0]     o_dump_data,
  output logic                  o_dump_last,
  input  logic                  i_dump_ready,
  output logic [N_BITS-1:0]     o_cycle_count,
  output logic                  o_halted,
  output logic                  o_timeout
);

  // Reject configurations that cannot address every dumped register.
  if (N_REGS < 1 || N_REGS > (1 << N_REG_BITS) || MAX_CYCLES < 1) begin : g_param_check
    $error("pipeline_debug_sequencer: illegal parameter combination");
  end

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

  localparam logic [N_REG_BITS-1:0] LAST_ADDR = N_REG_BITS'(N_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DUMP_RD,
    S_DUMP_SEND,
    S_HALTED
  } state_t;

  state_t                  state_q, state_d;
  logic                    ret_halted_q, ret_halted_d;
  logic [N_REG_BITS-1:0]   addr_q, addr_d;
  logic [N_BITS-1:0]       dump_data_q;
  logic [N_BITS-1:0]       cycle_count_q;
  logic                    pipe_en;
  logic                    cmd_ready;
  logic                    dump_valid;
  logic                    capture;
  logic                    is_last;
  logic                    limit_hit;

  assign is_last = (addr_q == LAST_ADDR);

`ifdef DBG_CYCLE_LIMIT_EN
  logic timeout_q;

  assign limit_hit = (cycle_count_q == N_BITS'(MAX_CYCLES - 1));

  // Sticky timeout flag, set when a RUN is stopped by the cycle limit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      timeout_q <= 1'b0;
    end else if (state_q == S_RUN && pipe_en && limit_hit) begin
      timeout_q <= 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign limit_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Next-state, command acceptance and per-state output decode.
  always_comb begin
    state_d      = state_q;
    ret_halted_d = ret_halted_q;
    addr_d       = addr_q;
    pipe_en      = 1'b0;
    cmd_ready    = 1'b0;
    dump_valid   = 1'b0;
    capture      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_RUN:  state_d = S_RUN;
            CMD_STEP: state_d = S_STEP;
            CMD_DUMP: begin
              state_d      = S_DUMP_RD;
              addr_d       = '0;
              ret_halted_d = 1'b0;
            end
            CMD_NOP:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        pipe_en = !i_halt;
        if (i_halt) begin
          state_d = S_HALTED;
        end else if (limit_hit) begin
          state_d = S_HALTED;
        end
      end
      S_STEP: begin
        pipe_en = !i_halt;
        state_d = i_halt ? S_HALTED : S_IDLE;
      end
      S_DUMP_RD: begin
        capture = 1'b1;
        state_d = S_DUMP_SEND;
      end
      S_DUMP_SEND: begin
        dump_valid = 1'b1;
        if (i_dump_ready) begin
          if (is_last) begin
            addr_d  = '0;
            state_d = ret_halted_q ? S_HALTED : S_IDLE;
          end else begin
            addr_d  = addr_q + N_REG_BITS'(1);
            state_d = S_DUMP_RD;
          end
        end
      end
      S_HALTED: begin
        cmd_ready = 1'b1;
        // RUN/STEP/NOP are consumed but have no effect here.
        if (i_cmd_valid && i_cmd == CMD_DUMP) begin
          state_d      = S_DUMP_RD;
          addr_d       = '0;
          ret_halted_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, dump bookkeeping and saturating enabled-cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      ret_halted_q  <= 1'b0;
      addr_q        <= '0;
      dump_data_q   <= '0;
      cycle_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ret_halted_q <= ret_halted_d;
      addr_q       <= addr_d;
      if (capture) begin
        dump_data_q <= i_dbg_reg_data;
      end
      if (pipe_en && cycle_count_q != '1) begin
        cycle_count_q <= cycle_count_q + N_BITS'(1);
      end
    end
  end

  assign o_cmd_ready    = cmd_ready;
  assign o_pipe_enable  = pipe_en;
  assign o_dbg_reg_addr = addr_q;
  assign o_dump_valid   = dump_valid;
  assign o_dump_data    = dump_data_q;
  assign o_dump_last    = dump_valid & is_last;
  assign o_cycle_count  = cycle_count_q;
  assign o_halted       = (state_q == S_HALTED);

endmodule

// File: tb/tb_pipeline_debug_sequencer.sv
// Directed + randomized bench for pipeline_debug_sequencer. A small
// transaction-level model (enabled-cycle tally, halted/timeout flags and a
// register-file image) predicts every checked value.
module tb_pipeline_debug_sequencer;
  localparam int NB   = 32;
  localparam int NRB  = 5;
  localparam int NR   = 32;
  localparam int MAXC = 16;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_DUMP = 2'b11;

`ifdef DBG_CYCLE_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic           i_clk = 1'b0;
  logic           i_reset;
  logic           i_cmd_valid;
  logic [1:0]     i_cmd;
  logic           o_cmd_ready;
  logic           i_halt;
  logic           o_pipe_enable;
  logic [NRB-1:0] o_dbg_reg_addr;
  logic [NB-1:0]  i_dbg_reg_data;
  logic           o_dump_valid;
  logic [NB-1:0]  o_dump_data;
  logic           o_dump_last;
  logic           i_dump_ready;
  logic [NB-1:0]  o_cycle_count;
  logic           o_halted;
  logic           o_timeout;

  logic [NB-1:0]  reg_mem [NR];

  int tests = 0;
  int fails = 0;
  int m_count;
  bit m_halted;
  bit m_timeout;

  pipeline_debug_sequencer #(
    .N_BITS(NB), .N_REG_BITS(NRB), .N_REGS(NR), .MAX_CYCLES(MAXC)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(o_cmd_ready), .i_halt(i_halt), .o_pipe_enable(o_pipe_enable),
    .o_dbg_reg_addr(o_dbg_reg_addr), .i_dbg_reg_data(i_dbg_reg_data),
    .o_dump_valid(o_dump_valid), .o_dump_data(o_dump_data), .o_dump_last(o_dump_last),
    .i_dump_ready(i_dump_ready), .o_cycle_count(o_cycle_count), .o_halted(o_halted),
    .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  assign i_dbg_reg_data = reg_mem[o_dbg_reg_addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_rest(input string tag);
    check({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
    check({tag, "_pipe_enable"}, o_pipe_enable, 1'b0);
    check({tag, "_halted"}, o_halted, m_halted);
    check({tag, "_dump_valid"}, o_dump_valid, 1'b0);
    check({tag, "_dump_last"}, o_dump_last, 1'b0);
    check({tag, "_dbg_addr"}, o_dbg_reg_addr, 0);
    check({tag, "_cycle_count"}, o_cycle_count, 64'(m_count));
    check({tag, "_timeout"}, o_timeout, m_timeout);
  endtask

  task automatic apply_reset(input string tag);
    i_reset = 1'b1; i_cmd_valid = 1'b0; i_cmd = CMD_NOP; i_halt = 1'b0; i_dump_ready = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    settle();
    m_count = 0; m_halted = 1'b0; m_timeout = 1'b0;
    check_rest(tag);
    check({tag, "_dump_data"}, o_dump_data, 0);
  endtask

  task automatic send_cmd(input logic [1:0] c, input string tag);
    i_cmd_valid = 1'b1;
    i_cmd = c;
    settle();
    check({tag, "_cmd_ready"}, o_cmd_ready, 1'b1);
    tick();
    i_cmd_valid = 1'b0;
    i_cmd = CMD_NOP;
  endtask

  // Caller has just issued an accepted RUN. halt_at = RUN cycle on which
  // i_halt is raised (0: never); ncycles = cycles observed.
  task automatic run_phase(input int halt_at, input int ncycles);
    bit in_run = 1'b1;
    for (int j = 1; j <= ncycles; j++) begin
      i_halt = (j == halt_at);
      settle();
      check("run_pipe_enable", o_pipe_enable, in_run && !i_halt);
      if (in_run) begin
        if (i_halt) begin
          in_run = 1'b0; m_halted = 1'b1;
        end else begin
          if (LIMIT_ON && m_count == MAXC - 1) begin
            in_run = 1'b0; m_halted = 1'b1; m_timeout = 1'b1;
          end
          m_count++;
        end
      end
      tick();
    end
    i_halt = 1'b0;
    settle();
    check("run_cycle_count", o_cycle_count, 64'(m_count));
    check("run_halted", o_halted, m_halted);
    check("run_cmd_ready", o_cmd_ready, m_halted);
    check("run_timeout", o_timeout, m_timeout);
  endtask

  task automatic do_step(input bit h);
    send_cmd(CMD_STEP, "step");
    i_halt = h;
    settle();
    check("step_pipe_enable", o_pipe_enable, !h);
    if (h) m_halted = 1'b1;
    else m_count++;
    tick();
    i_halt = 1'b0;
    settle();
    check_rest("step_after");
  endtask

  // Dump with optional random backpressure, a forced stall on one word and
  // an optional reset while a given word is pending.
  task automatic do_dump(input bit rand_ready, input int stall_word, input int stall_len,
                         input int reset_word);
    int widx = 0;
    int stall = 0;
    int budget = 0;
    bit done = 1'b0;
    send_cmd(CMD_DUMP, "dump");
    while (!done) begin
      if (budget++ > 2000) begin
        check("dump_budget_words", widx, NR);
        break;
      end
      i_dump_ready = (widx == stall_word && stall < stall_len) ? 1'b0 :
                     (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      settle();
      check("dump_pipe_enable", o_pipe_enable, 1'b0);
      if (o_dump_valid) begin
        check("dump_data", o_dump_data, reg_mem[widx]);
        check("dump_last", o_dump_last, widx == NR - 1);
        check("dump_addr", o_dbg_reg_addr, widx);
        if (widx == reset_word) begin
          i_reset = 1'b1;
          tick();
          i_reset = 1'b0;
          i_dump_ready = 1'b0;
          settle();
          m_count = 0; m_halted = 1'b0; m_timeout = 1'b0;
          check_rest("mid_dump_reset");
          check("mid_dump_reset_data", o_dump_data, 0);
          return;
        end
        if (widx == stall_word && !i_dump_ready) stall++;
        if (i_dump_ready) begin
          widx++;
          if (widx == NR) done = 1'b1;
        end
      end
      tick();
    end
    i_dump_ready = 1'b0;
    settle();
    check("dump_word_total", widx, NR);
    check_rest("dump_return");
  endtask

  initial begin
    for (int i = 0; i < NR; i++) reg_mem[i] = NB'(32'h100 + i);

    apply_reset("reset");

    // RUN with halt on the 10th RUN cycle: nine enabled cycles.
    send_cmd(CMD_RUN, "run10");
    run_phase(10, 12);
    check("run10_count", o_cycle_count, 9);

    // In HALTED, RUN is swallowed and i_halt has no influence.
    send_cmd(CMD_RUN, "halted_run");
    for (int k = 0; k < 4; k++) begin
      i_halt = 1'($urandom_range(0, 1));
      settle();
      check("halted_pipe_enable", o_pipe_enable, 1'b0);
      check("halted_flag", o_halted, 1'b1);
      tick();
    end
    i_halt = 1'b0;

    // Three single steps from IDLE.
    apply_reset("reset2");
    do_step(1'b0); do_step(1'b0); do_step(1'b0);
    check("step3_count", o_cycle_count, 3);

    send_cmd(CMD_NOP, "nop");
    settle();
    check_rest("nop_after");

    // Full dump of the 0x100+addr image, no backpressure.
    do_dump(1'b0, -1, 0, -1);

    // Random image, five-cycle stall on word 7.
    for (int i = 0; i < NR; i++) reg_mem[i] = $urandom;
    do_dump(1'b0, 7, 5, -1);

    // Step that meets a halt lands in HALTED; dumps return there.
    do_step(1'b1);
    send_cmd(CMD_RUN, "halted_run2");
    settle();
    check("halted_run2_pipe_enable", o_pipe_enable, 1'b0);
    do_dump(1'b1, -1, 0, -1);
    do_dump(1'b1, -1, 0, 4);

    // Long RUN without halt: cycle limit build stops at MAXC cycles.
    send_cmd(CMD_RUN, "limit_run");
    run_phase(0, 24);
`ifdef DBG_CYCLE_LIMIT_EN
    check("limit_count", o_cycle_count, 16);
    check("limit_timeout", o_timeout, 1'b1);
`else
    check("nolimit_count", o_cycle_count, 24);
    check("nolimit_timeout", o_timeout, 1'b0);
`endif
    apply_reset("reset3");

    // Randomized halt points, each followed by a randomly throttled dump.
    for (int r = 0; r < 6; r++) begin
      int h;
      h = int'($urandom_range(1, 12));
      send_cmd(CMD_RUN, "rand_run");
      run_phase(h, 14);
      check("rand_run_count", o_cycle_count, 64'(h - 1));
      for (int i = 0; i < NR; i++) reg_mem[i] = $urandom;
      do_dump(1'b1, int'($urandom_range(0, NR - 1)), int'($urandom_range(0, 4)), -1);
      apply_reset("rand_reset");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
